// File: rtl/rvl_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvl_stim_pkg
// Description : Shared state encoding and timing constants for the stimulus
//               player.
// Revision    : 1.0 - initial release
// ============================================================================
package rvl_stim_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_PRIME = 2'd2;
    localparam logic [1:0] S_PLAY  = 2'd3;

    // Cycles from a sampled start to sample 0 on stim_dout (no trigger wait).
    localparam int unsigned START_LAT = 2;

endpackage : rvl_stim_pkg
`default_nettype wire

// File: rtl/rvl_stim_ram.sv
`default_nettype none
// ============================================================================
// Module      : rvl_stim_ram
// Description : DEPTH x WIDTH simple dual-port pattern table, synchronous
//               read with one cycle of latency and a held read register.
// Revision    : 1.0 - initial release
// ============================================================================
module rvl_stim_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // The read register only moves on rd_en so it can double as the held output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : rvl_stim_ram
`default_nettype wire

// File: rtl/rvl_stim_player.sv
`default_nettype none
// ============================================================================
// Module      : rvl_stim_player
// Description : JTAG-loaded stimulus player; replays a pattern table onto the
//               nets under test, one-shot or looped, with a per-sample hold.
//               Optional start-trigger qualifier: define RVL_STIM_TRIG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rvl_stim_player
    import rvl_stim_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH),
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              host_wr,
    input  logic [AW-1:0]     host_addr,
    input  logic [WIDTH-1:0]  host_wdata,
    output logic              host_wr_err,
    input  logic              ctrl_start,
    input  logic              ctrl_stop,
    input  logic              ctrl_loop,
    input  logic [AW-1:0]     ctrl_last,
    input  logic [HOLD_W-1:0] ctrl_hold,
    input  logic              trigger_in,
    output logic [WIDTH-1:0]  stim_dout,
    output logic              stim_valid,
    output logic              busy,
    output logic              done
);

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [AW-1:0]     last_q, last_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              loop_q, loop_d;
    logic              done_q, done_d;
    logic              wr_err_q;

    logic              ram_we;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic              last_hold;

    assign ram_we    = host_wr && (state_q == S_IDLE);
    assign last_hold = (cnt_q == hold_q);

`ifndef RVL_STIM_TRIG_EN
    logic unused_trigger;
    assign unused_trigger = trigger_in;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        hold_d  = hold_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;

        if (ctrl_stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctrl_start && !ctrl_stop) begin
                        loop_d  = ctrl_loop;
                        last_d  = ctrl_last;
                        hold_d  = ctrl_hold;
`ifdef RVL_STIM_TRIG_EN
                        state_d = S_ARMED;
`else
                        state_d = S_PRIME;
`endif
                    end
                end
                S_ARMED: begin
`ifdef RVL_STIM_TRIG_EN
                    if (trigger_in) begin
                        state_d = S_PRIME;
                    end
`else
                    state_d = S_PRIME;
`endif
                end
                S_PRIME: begin
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_PLAY;
                end
                S_PLAY: begin
                    // The next read is issued on the final hold cycle so samples abut.
                    if (!last_hold) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (idx_q != last_q) begin
                        rd_en   = 1'b1;
                        rd_addr = idx_q + 1'b1;
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = '0;
                    end else if (loop_q) begin
                        rd_en   = 1'b1;
                        rd_addr = '0;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
            hold_q   <= '0;
            loop_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            loop_q   <= loop_d;
            done_q   <= done_d;
            wr_err_q <= host_wr && (state_q != S_IDLE);
        end
    end

    rvl_stim_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (ram_we),
        .wr_addr_i (host_addr),
        .wr_data_i (host_wdata),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (stim_dout)
    );

    assign stim_valid  = (state_q == S_PLAY);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign host_wr_err = wr_err_q;

endmodule : rvl_stim_player
`default_nettype wire

// File: tb/tb_rvl_stim_player.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rvl_stim_player
// Description : Self-checking bench for rvl_stim_player with a cycle-indexed
//               reference model of the replay schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvl_stim_player;
    import rvl_stim_pkg::*;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int HOLD_W = 8;
`ifdef RVL_STIM_TRIG_EN
    localparam int LAT     = START_LAT + 1;
    localparam bit TRIG_ON = 1'b1;
`else
    localparam int LAT     = START_LAT;
    localparam bit TRIG_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              host_wr;
    logic [AW-1:0]     host_addr;
    logic [WIDTH-1:0]  host_wdata;
    logic              host_wr_err;
    logic              ctrl_start;
    logic              ctrl_stop;
    logic              ctrl_loop;
    logic [AW-1:0]     ctrl_last;
    logic [HOLD_W-1:0] ctrl_hold;
    logic              trigger_in;
    logic [WIDTH-1:0]  stim_dout;
    logic              stim_valid;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] model_mem [DEPTH];
    logic [WIDTH-1:0] exp_dout;
    int               cfg_last;
    int               cfg_hold;
    bit               cfg_loop;

    rvl_stim_player #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .HOLD_W (HOLD_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .host_wr     (host_wr),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_wr_err (host_wr_err),
        .ctrl_start  (ctrl_start),
        .ctrl_stop   (ctrl_stop),
        .ctrl_loop   (ctrl_loop),
        .ctrl_last   (ctrl_last),
        .ctrl_hold   (ctrl_hold),
        .trigger_in  (trigger_in),
        .stim_dout   (stim_dout),
        .stim_valid  (stim_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        host_wr    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        ctrl_start = 1'b0;
        ctrl_stop  = 1'b0;
        ctrl_loop  = 1'b0;
        ctrl_last  = '0;
        ctrl_hold  = '0;
        trigger_in = TRIG_ON;
    endtask

    task automatic load_entry(input int a, input logic [WIDTH-1:0] d);
        @(negedge clk);
        host_wr    = 1'b1;
        host_addr  = AW'(a);
        host_wdata = d;
        model_mem[a] = d;
        @(negedge clk);
        host_wr = 1'b0;
        checks++;
        if (host_wr_err !== 1'b0)
            $display("FAIL load_err addr=%0d got %b want 0", a, host_wr_err);
    endtask

    // Expected outputs c cycles after the start cycle, from the replay rules.
    task automatic model_at(input int c, input int stop_at, output bit busy_e, output bit valid_e,
                            output bit done_e, output logic [WIDTH-1:0] dout_e);
        int per, k, r;
        per     = cfg_hold + 1;
        busy_e  = 1'b0;
        valid_e = 1'b0;
        done_e  = 1'b0;
        dout_e  = exp_dout;
        if ((stop_at >= 0 && c > stop_at) || c == 0) return;
        if (c < LAT) begin
            busy_e = 1'b1;
            return;
        end
        k = (c - LAT) / per;
        r = (c - LAT) % per;
        if (cfg_loop) begin
            busy_e = 1'b1; valid_e = 1'b1; dout_e = model_mem[k % (cfg_last + 1)];
        end else if (k <= cfg_last) begin
            busy_e = 1'b1; valid_e = 1'b1; dout_e = model_mem[k];
        end else if (k == cfg_last + 1 && r == 0) begin
            done_e = 1'b1;
        end
    endtask

    // Starts a run at c=0 and compares every output each cycle against the model.
    task automatic run_scenario(input string tag, input int n, input int stop_at,
                                input int restart_at, input int wr_at);
        bit b, v, d, e, wr_busy;
        logic [WIDTH-1:0] o, wv;
        wr_busy = 1'b0;
        wv = 8'($urandom);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            model_at(c, stop_at, b, v, d, o);
            e = (c == wr_at + 1) && wr_busy;
            checks += 5;
            if (stim_dout !== o)   $display("FAIL %s dout c=%0d got %h want %h", tag, c, stim_dout, o);
            if (stim_valid !== v)  $display("FAIL %s valid c=%0d got %b want %b", tag, c, stim_valid, v);
            if (busy !== b)        $display("FAIL %s busy c=%0d got %b want %b", tag, c, busy, b);
            if (done !== d)        $display("FAIL %s done c=%0d got %b want %b", tag, c, done, d);
            if (host_wr_err !== e) $display("FAIL %s wr_err c=%0d got %b want %b", tag, c, host_wr_err, e);
            if (stim_dout !== o || stim_valid !== v || busy !== b || done !== d || host_wr_err !== e)
                errors++;
            exp_dout = o;
            ctrl_start = (c == 0) || (c == restart_at);
            ctrl_stop  = (c == stop_at);
            if (c == 0) begin
                ctrl_loop = cfg_loop;
                ctrl_last = AW'(cfg_last);
                ctrl_hold = HOLD_W'(cfg_hold);
            end else begin
                ctrl_loop = 1'($urandom);
                ctrl_last = AW'($urandom);
                ctrl_hold = HOLD_W'($urandom);
            end
            host_wr    = (c == wr_at);
            host_addr  = AW'(1);
            host_wdata = wv;
            if (c == wr_at) begin
                wr_busy = b;
                if (!b) model_mem[1] = wv;
            end
            trigger_in = TRIG_ON ? 1'b1 : 1'($urandom);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (stim_dout !== '0)    begin errors++; $display("FAIL reset_dout got %h want 00", stim_dout); end
        if (stim_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", stim_valid); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if (host_wr_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", host_wr_err); end
        reset_n  = 1'b1;
        exp_dout = '0;
    endtask

    task automatic load_basic();
        load_entry(0, 8'h11);
        load_entry(1, 8'h22);
        load_entry(2, 8'h33);
        load_entry(3, 8'h44);
    endtask

    task automatic test_oneshot();
        load_basic();
        cfg_last = 3; cfg_hold = 0; cfg_loop = 1'b0;
        run_scenario("oneshot", 10, -1, -1, -1);
    endtask

    task automatic test_loop_stop();
        cfg_last = 3; cfg_hold = 2; cfg_loop = 1'b1;
        run_scenario("loop_stop", 26, 20, -1, -1);
    endtask

    task automatic test_wr_busy();
        cfg_last = 3; cfg_hold = 1; cfg_loop = 1'b0;
        run_scenario("wr_busy", 14, -1, -1, 5);
        cfg_hold = 0;
        run_scenario("wr_retained", 9, -1, -1, -1);
        load_entry(1, 8'h5A);
        run_scenario("wr_idle", 9, -1, -1, -1);
    endtask

    task automatic test_start_stop();
        cfg_last = 3; cfg_hold = 0; cfg_loop = 1'b0;
        run_scenario("start_stop", 5, 0, -1, -1);
    endtask

    task automatic test_back_to_back();
        cfg_last = 3; cfg_hold = 0; cfg_loop = 1'b0;
        run_scenario("restart_ignored", 10, -1, 3, -1);
    endtask

    task automatic test_single();
        cfg_last = 0; cfg_hold = 0; cfg_loop = 1'b1;
        run_scenario("single_loop", 10, 7, -1, -1);
        cfg_loop = 1'b0; cfg_hold = 3;
        run_scenario("single_oneshot", 9, -1, -1, -1);
    endtask

    task automatic test_async_reset();
        cfg_last = 3; cfg_hold = 1; cfg_loop = 1'b1;
        run_scenario("pre_reset", 8, -1, -1, -1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks += 4;
        if (stim_dout !== '0)    begin errors++; $display("FAIL areset_dout got %h want 00", stim_dout); end
        if (stim_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", stim_valid); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
        if (done !== 1'b0)       begin errors++; $display("FAIL areset_done got %b want 0", done); end
        @(negedge clk);
        reset_n  = 1'b1;
        exp_dout = '0;
        cfg_hold = 0; cfg_loop = 1'b0;
        run_scenario("post_reset", 9, -1, -1, -1);
    endtask

    task automatic test_random();
        int n, stop_at;
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < DEPTH; a++) load_entry(a, 8'($urandom));
            cfg_last = $urandom_range(0, DEPTH - 1);
            cfg_hold = $urandom_range(0, 3);
            cfg_loop = 1'($urandom);
            n = LAT + (cfg_last + 1) * (cfg_hold + 1) + 4;
            stop_at = (cfg_loop || ($urandom_range(0, 1) == 1)) ? $urandom_range(1, n - 3) : -1;
            run_scenario("random", n, stop_at, -1, -1);
        end
    endtask

    task automatic test_trigger();
`ifdef RVL_STIM_TRIG_EN
        bit bv, vv;
        cfg_last = 3; cfg_hold = 3; cfg_loop = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            bv = (c >= 1);
            vv = (c >= 12);
            checks += 2;
            if (busy !== bv)       begin errors++; $display("FAIL trig_busy c=%0d got %b want %b", c, busy, bv); end
            if (stim_valid !== vv) begin errors++; $display("FAIL trig_valid c=%0d got %b want %b", c, stim_valid, vv); end
            if (c == 12) begin
                checks++;
                if (stim_dout !== model_mem[0]) begin
                    errors++;
                    $display("FAIL trig_dout got %h want %h", stim_dout, model_mem[0]);
                end
            end
            ctrl_start = (c == 0);
            ctrl_loop  = cfg_loop;
            ctrl_last  = AW'(cfg_last);
            ctrl_hold  = HOLD_W'(cfg_hold);
            trigger_in = (c == 10);
            ctrl_stop  = (c == 14);
        end
        @(negedge clk);
        idle_inputs();
        exp_dout = model_mem[0];
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL trig_stop_busy got %b want 0", busy); end
`else
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            trigger_in = (c % 2 == 0);
            checks += 2;
            if (busy !== 1'b0)       begin errors++; $display("FAIL notrig_busy c=%0d got %b want 0", c, busy); end
            if (stim_valid !== 1'b0) begin errors++; $display("FAIL notrig_valid c=%0d got %b want 0", c, stim_valid); end
        end
        @(negedge clk);
        idle_inputs();
`endif
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_loop_stop();
        test_wr_busy();
        test_start_stop();
        test_back_to_back();
        test_single();
        test_async_reset();
        test_trigger();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rvl_stim_player
`default_nettype wire
